// File: rtl/retire_trace_unit.sv
// Retire trace unit: captures one record per retired instruction into a
// small FIFO and streams the records to an external checker over a
// valid/ready handshake. A halt retirement stops capture; once the queued
// records have drained the unit reports done until the next reset.
module retire_trace_unit #(
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   // Writeback (retire) port
   input  logic                     wb_valid,
   input  logic [31:0]              wb_pc,
   input  logic [31:0]              wb_instr,
   input  logic                     wb_rd_we,
   input  logic [4:0]               wb_rd,
   input  logic [31:0]              wb_rd_data,
   input  logic                     wb_mem_we,
   input  logic [31:0]              wb_mem_addr,
   input  logic [31:0]              wb_mem_data,
   input  logic                     wb_halt,
   // Trace stream to the checker
   output logic                     tr_valid,
   input  logic                     tr_ready,
   output logic [31:0]              tr_seq,
   output logic [31:0]              tr_pc,
   output logic [31:0]              tr_instr,
   output logic                     tr_rd_we,
   output logic [4:0]               tr_rd,
   output logic [31:0]              tr_rd_data,
   output logic                     tr_mem_we,
   output logic [31:0]              tr_mem_addr,
   output logic [31:0]              tr_mem_data,
   output logic                     tr_last,
   // Status
   output logic                     stall_req,
   output logic                     overflow,
   output logic                     done,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
   localparam logic [CW-1:0] STALL_CNT = CW'(DEPTH - 2);

   typedef struct packed {
      logic [31:0] seq;
      logic [31:0] pc;
      logic [31:0] instr;
      logic        rd_we;
      logic [4:0]  rd;
      logic [31:0] rd_data;
      logic        mem_we;
      logic [31:0] mem_addr;
      logic [31:0] mem_data;
      logic        last;
   } rec_t;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t          state;
   logic            done_q;
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [CW-1:0]   count_q;
   logic [CW-1:0]   count_next;
   logic [31:0]     seq_q;
   logic            overflow_q;

   rec_t            mem [DEPTH];
   rec_t            wr_rec;
   rec_t            head_rec;

   logic            push_en;
   logic            full;
   logic            pop;
   logic            accept;
   logic            drop;

   // Handshake qualifiers. A push at full is still accepted when the head
   // leaves on the same edge, since the slot being freed is the one written.
   assign push_en = wb_valid && (state == RUN);
   assign full    = (count_q == FULL_CNT);
   assign pop     = tr_valid && tr_ready;
   assign accept  = push_en && (!full || pop);
   assign drop    = push_en && full && !pop;

   // Next occupancy from the push/pop combination.
   always_comb begin
      // NOTE: default assignment first so no path leaves count_next unassigned (no latch).
      count_next = count_q;
      unique case ({accept, pop})
         2'b10:   count_next = count_q + CW'(1);
         2'b01:   count_next = count_q - CW'(1);
         default: count_next = count_q;
      endcase
   end

   // Build the record to store; writes to x0 are architecturally invisible.
   always_comb begin
      wr_rec          = '0;
      wr_rec.seq      = seq_q;
      wr_rec.pc       = wb_pc;
      wr_rec.instr    = wb_instr;
      wr_rec.rd       = wb_rd;
      wr_rec.rd_we    = wb_rd_we && (wb_rd != 5'd0);
      wr_rec.rd_data  = (wb_rd == 5'd0) ? 32'd0 : wb_rd_data;
      wr_rec.mem_we   = wb_mem_we;
      wr_rec.mem_addr = wb_mem_addr;
      wr_rec.mem_data = wb_mem_data;
      wr_rec.last     = wb_halt;
   end

   // Record storage write port.
   // NOTE: storage is deliberately not reset; every read is qualified by tr_valid.
   always_ff @(posedge clk) begin
      if (accept) begin
         mem[wr_ptr] <= wr_rec;
      end
   end

   // Pointers, occupancy, retire counter and sticky overflow.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count_q    <= '0;
         seq_q      <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (accept) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         count_q <= count_next;
         // Dropped records still consume a sequence number.
         if (push_en) begin
            seq_q <= seq_q + 32'd1;
         end
         if (drop) begin
            overflow_q <= 1'b1;
         end
      end
   end

   // Capture state machine: RUN until halt retires, DRAIN until empty, then DONE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= RUN;
         done_q <= 1'b0;
      end else begin
         unique case (state)
            RUN: begin
               // Halt ends capture whether its record was stored or dropped.
               if (wb_valid && wb_halt) begin
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               if (count_next == '0) begin
                  state  <= DONE;
                  done_q <= 1'b1;
               end
            end
            DONE: begin
               state  <= DONE;
            end
            default: begin
               state  <= RUN;
               done_q <= 1'b0;
            end
         endcase
      end
   end

   // Head of queue drives the trace record outputs.
   assign head_rec    = mem[rd_ptr];
   assign tr_valid    = (count_q != '0);
   assign tr_seq      = head_rec.seq;
   assign tr_pc       = head_rec.pc;
   assign tr_instr    = head_rec.instr;
   assign tr_rd_we    = head_rec.rd_we;
   assign tr_rd       = head_rec.rd;
   assign tr_rd_data  = head_rec.rd_data;
   assign tr_mem_we   = head_rec.mem_we;
   assign tr_mem_addr = head_rec.mem_addr;
   assign tr_mem_data = head_rec.mem_data;
   assign tr_last     = head_rec.last;

   // Stall two entries early so the CPU's one-cycle stall latency cannot overflow.
   assign stall_req   = (count_q >= STALL_CNT);
   assign overflow    = overflow_q;
   assign done        = done_q;
   assign count       = count_q;

endmodule

// File: tb/tb_retire_trace_unit.sv
// Self-checking bench for retire_trace_unit: table vectors, directed
// multi-cycle sequences, and random traffic against a queue-based model.
module tb_retire_trace_unit;

   localparam int DEPTH = 8;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clk;
   logic          rst;
   logic          wb_valid;
   logic [31:0]   wb_pc;
   logic [31:0]   wb_instr;
   logic          wb_rd_we;
   logic [4:0]    wb_rd;
   logic [31:0]   wb_rd_data;
   logic          wb_mem_we;
   logic [31:0]   wb_mem_addr;
   logic [31:0]   wb_mem_data;
   logic          wb_halt;
   logic          tr_valid;
   logic          tr_ready;
   logic [31:0]   tr_seq;
   logic [31:0]   tr_pc;
   logic [31:0]   tr_instr;
   logic          tr_rd_we;
   logic [4:0]    tr_rd;
   logic [31:0]   tr_rd_data;
   logic          tr_mem_we;
   logic [31:0]   tr_mem_addr;
   logic [31:0]   tr_mem_data;
   logic          tr_last;
   logic          stall_req;
   logic          overflow;
   logic          done;
   logic [CW-1:0] count;

   retire_trace_unit #(.DEPTH(DEPTH)) dut (
      .clk         (clk),
      .rst         (rst),
      .wb_valid    (wb_valid),
      .wb_pc       (wb_pc),
      .wb_instr    (wb_instr),
      .wb_rd_we    (wb_rd_we),
      .wb_rd       (wb_rd),
      .wb_rd_data  (wb_rd_data),
      .wb_mem_we   (wb_mem_we),
      .wb_mem_addr (wb_mem_addr),
      .wb_mem_data (wb_mem_data),
      .wb_halt     (wb_halt),
      .tr_valid    (tr_valid),
      .tr_ready    (tr_ready),
      .tr_seq      (tr_seq),
      .tr_pc       (tr_pc),
      .tr_instr    (tr_instr),
      .tr_rd_we    (tr_rd_we),
      .tr_rd       (tr_rd),
      .tr_rd_data  (tr_rd_data),
      .tr_mem_we   (tr_mem_we),
      .tr_mem_addr (tr_mem_addr),
      .tr_mem_data (tr_mem_data),
      .tr_last     (tr_last),
      .stall_req   (stall_req),
      .overflow    (overflow),
      .done        (done),
      .count       (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [31:0] seq;
      logic [31:0] pc;
      logic [31:0] instr;
      logic        rd_we;
      logic [4:0]  rd;
      logic [31:0] rd_data;
      logic        mem_we;
      logic [31:0] mem_addr;
      logic [31:0] mem_data;
      logic        last;
   } mrec_t;

   mrec_t       mq[$];
   logic [31:0] m_seq;
   int          m_phase;   // 0 capturing, 1 draining after halt, 2 finished
   bit          m_ovf;

   task automatic model_reset();
      mq.delete();
      m_seq   = 32'd0;
      m_phase = 0;
      m_ovf   = 1'b0;
   endtask

   // Apply one clock edge to the model using the inputs currently driven.
   task automatic model_edge();
      mrec_t r;
      bit    was_draining;
      was_draining = (m_phase == 1);
      if (mq.size() > 0 && tr_ready) void'(mq.pop_front());
      if (m_phase == 0 && wb_valid) begin
         r.seq      = m_seq;
         r.pc       = wb_pc;
         r.instr    = wb_instr;
         r.rd       = wb_rd;
         r.rd_we    = wb_rd_we && (wb_rd != 0);
         r.rd_data  = (wb_rd == 0) ? 32'd0 : wb_rd_data;
         r.mem_we   = wb_mem_we;
         r.mem_addr = wb_mem_addr;
         r.mem_data = wb_mem_data;
         r.last     = wb_halt;
         if (mq.size() < DEPTH) mq.push_back(r);
         else m_ovf = 1'b1;
         m_seq = m_seq + 32'd1;
         if (wb_halt) m_phase = 1;
      end
      if (was_draining && mq.size() == 0) m_phase = 2;
   endtask

   task automatic compare_outputs();
      check("tr_valid", tr_valid, mq.size() > 0);
      check("count", count, mq.size());
      check("stall_req", stall_req, mq.size() >= DEPTH - 2);
      check("overflow", overflow, m_ovf);
      check("done", done, m_phase == 2);
      if (mq.size() > 0) begin
         check("tr_seq", tr_seq, mq[0].seq);
         check("tr_pc", tr_pc, mq[0].pc);
         check("tr_instr", tr_instr, mq[0].instr);
         check("tr_rd_we", tr_rd_we, mq[0].rd_we);
         check("tr_rd", tr_rd, mq[0].rd);
         check("tr_rd_data", tr_rd_data, mq[0].rd_data);
         check("tr_mem_we", tr_mem_we, mq[0].mem_we);
         check("tr_mem_addr", tr_mem_addr, mq[0].mem_addr);
         check("tr_mem_data", tr_mem_data, mq[0].mem_data);
         check("tr_last", tr_last, mq[0].last);
      end
   endtask

   // One cycle: compare at the falling edge, advance DUT and model on the
   // rising edge, return 1 time unit later so callers may drive new inputs.
   task automatic step();
      @(negedge clk);
      compare_outputs();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic idle_inputs();
      wb_valid    = 1'b0;
      wb_pc       = 32'd0;
      wb_instr    = 32'd0;
      wb_rd_we    = 1'b0;
      wb_rd       = 5'd0;
      wb_rd_data  = 32'd0;
      wb_mem_we   = 1'b0;
      wb_mem_addr = 32'd0;
      wb_mem_data = 32'd0;
      wb_halt     = 1'b0;
   endtask

   task automatic retire(input logic [31:0] pc, input logic [31:0] instr,
                         input logic rd_we, input logic [4:0] rd, input logic [31:0] rd_data,
                         input logic mem_we, input logic [31:0] addr, input logic [31:0] data,
                         input logic halt);
      wb_valid    = 1'b1;
      wb_pc       = pc;
      wb_instr    = instr;
      wb_rd_we    = rd_we;
      wb_rd       = rd;
      wb_rd_data  = rd_data;
      wb_mem_we   = mem_we;
      wb_mem_addr = addr;
      wb_mem_data = data;
      wb_halt     = halt;
   endtask

   task automatic do_reset();
      idle_inputs();
      tr_ready = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
   endtask

   // ---------------- table vectors ----------------
   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        rd_we;
      logic [4:0]  rd;
      logic [31:0] rd_data;
      logic        mem_we;
      logic [31:0] addr;
      logic [31:0] data;
      logic [31:0] exp_seq;
      logic        exp_rd_we;
      logic [31:0] exp_rd_data;
   } vec_t;

   vec_t vt[4];

   initial begin
      #500000;
      $display("FAIL watchdog timeout actual=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      rst      = 1'b1;
      tr_ready = 1'b0;
      idle_inputs();
      model_reset();

      // Reset state, observed while reset is held.
      #12;
      check("rst_tr_valid", tr_valid, 1'b0);
      check("rst_count", count, 0);
      check("rst_stall", stall_req, 1'b0);
      check("rst_overflow", overflow, 1'b0);
      check("rst_done", done, 1'b0);
      do_reset();

      // ---- table: single retires streamed straight through ----
      vt[0] = '{32'h0000_0000, 32'h0050_0093, 1'b1, 5'd1,  32'd5,         1'b0, 32'h0,  32'h0,         32'd0, 1'b1, 32'd5};
      vt[1] = '{32'h0000_0004, 32'h0000_0013, 1'b1, 5'd0,  32'h0000_1234, 1'b0, 32'h0,  32'h0,         32'd1, 1'b0, 32'd0};
      vt[2] = '{32'h0000_0008, 32'h00a1_2823, 1'b0, 5'd16, 32'h0000_0077, 1'b1, 32'h10, 32'hDEAD_BEEF, 32'd2, 1'b0, 32'h77};
      vt[3] = '{32'h0000_000c, 32'hfff0_0f93, 1'b1, 5'd31, 32'hFFFF_FFFF, 1'b0, 32'h0,  32'h0,         32'd3, 1'b1, 32'hFFFF_FFFF};
      tr_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         retire(vt[i].pc, vt[i].instr, vt[i].rd_we, vt[i].rd, vt[i].rd_data,
                vt[i].mem_we, vt[i].addr, vt[i].data, 1'b0);
         step();
         idle_inputs();
         check("vec_valid", tr_valid, 1'b1);
         check("vec_seq", tr_seq, vt[i].exp_seq);
         check("vec_pc", tr_pc, vt[i].pc);
         check("vec_rd_we", tr_rd_we, vt[i].exp_rd_we);
         check("vec_rd_data", tr_rd_data, vt[i].exp_rd_data);
         check("vec_mem_data", tr_mem_data, vt[i].data);
         step();
         check("vec_popped", tr_valid, 1'b0);
      end

      // ---- backpressure: 10 retires into a stalled checker ----
      do_reset();
      tr_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         retire(32'h100 + 32'(i * 4), 32'h0000_0013, 1'b1, 5'd2, 32'(i), 1'b0, 32'h0, 32'h0, 1'b0);
         step();
         if (i == 4) check("bp_stall_at5", stall_req, 1'b0);
         if (i == 5) check("bp_stall_at6", stall_req, 1'b1);
      end
      idle_inputs();
      check("bp_count_full", count, 8);
      check("bp_overflow", overflow, 1'b1);
      tr_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         check("bp_order", tr_seq, k);
         step();
      end
      check("bp_empty", tr_valid, 1'b0);
      check("bp_overflow_sticky", overflow, 1'b1);

      // ---- simultaneous push and pop at full ----
      do_reset();
      tr_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         retire(32'h200 + 32'(i * 4), 32'h0000_0013, 1'b0, 5'd3, 32'd0, 1'b0, 32'h0, 32'h0, 1'b0);
         step();
      end
      check("pp_full", count, 8);
      tr_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         retire(32'h300 + 32'(i * 4), 32'h0000_0013, 1'b0, 5'd3, 32'd0, 1'b0, 32'h0, 32'h0, 1'b0);
         check("pp_head", tr_seq, i);
         step();
         check("pp_count", count, 8);
         check("pp_no_overflow", overflow, 1'b0);
      end
      idle_inputs();
      for (int k = 4; k < 12; k++) begin
         check("pp_order", tr_seq, k);
         step();
      end
      check("pp_empty", tr_valid, 1'b0);

      // ---- halt, drain and done ----
      do_reset();
      tr_ready = 1'b0;
      retire(32'h0, 32'h00a0_2823, 1'b0, 5'd0, 32'd0, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0);
      step();
      retire(32'h4, 32'h0010_0073, 1'b0, 5'd0, 32'd0, 1'b0, 32'h0, 32'h0, 1'b1);
      step();
      retire(32'h8, 32'h0000_0013, 1'b1, 5'd4, 32'd9, 1'b0, 32'h0, 32'h0, 1'b0);
      step();
      step();
      idle_inputs();
      check("halt_count", count, 2);
      check("halt_not_done", done, 1'b0);
      tr_ready = 1'b1;
      check("halt_rec0_addr", tr_mem_addr, 32'h10);
      check("halt_rec0_last", tr_last, 1'b0);
      step();
      check("halt_rec1_seq", tr_seq, 1);
      check("halt_rec1_last", tr_last, 1'b1);
      step();
      check("halt_done", done, 1'b1);
      check("halt_empty", tr_valid, 1'b0);
      retire(32'hC, 32'h0000_0013, 1'b1, 5'd4, 32'd9, 1'b0, 32'h0, 32'h0, 1'b0);
      step();
      step();
      idle_inputs();
      check("done_no_push", tr_valid, 1'b0);
      check("done_held", done, 1'b1);

      // ---- asynchronous reset in the middle of a drain ----
      do_reset();
      tr_ready = 1'b0;
      retire(32'h40, 32'h0000_0013, 1'b0, 5'd0, 32'd0, 1'b0, 32'h0, 32'h0, 1'b0);
      step();
      retire(32'h44, 32'h0000_0013, 1'b0, 5'd0, 32'd0, 1'b0, 32'h0, 32'h0, 1'b0);
      step();
      retire(32'h48, 32'h0010_0073, 1'b0, 5'd0, 32'd0, 1'b0, 32'h0, 32'h0, 1'b1);
      step();
      idle_inputs();
      check("ar_count3", count, 3);
      tr_ready = 1'b1;
      #2;
      rst = 1'b1;
      #1;
      check("ar_valid", tr_valid, 1'b0);
      check("ar_count", count, 0);
      check("ar_stall", stall_req, 1'b0);
      check("ar_done", done, 1'b0);
      rst = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      retire(32'h80, 32'h0050_0093, 1'b1, 5'd1, 32'd5, 1'b0, 32'h0, 32'h0, 1'b0);
      step();
      idle_inputs();
      check("ar_next_valid", tr_valid, 1'b1);
      check("ar_next_seq", tr_seq, 0);
      step();

      // ---- random traffic against the model ----
      for (int r = 0; r < 4; r++) begin
         do_reset();
         for (int c = 0; c < 500; c++) begin
            if ($urandom_range(0, 99) < 60) begin
               retire($urandom, $urandom, 1'($urandom), 5'($urandom_range(0, 31)), $urandom,
                      1'($urandom), $urandom, $urandom, ($urandom_range(0, 299) == 0));
               if ($urandom_range(0, 7) == 0) wb_rd = 5'd0;
            end else begin
               idle_inputs();
            end
            tr_ready = ($urandom_range(0, 99) < ((r % 2 == 1) ? 30 : 75));
            step();
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/retire_trace_unit.md
RETIRE_TRACE_UNIT -- requirements
Module: retire_trace_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 8, trace FIFO entries (power of 2, >=4).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port wb_valid  input  1  an instruction retires from WB this cycle.
REQ-005 SHALL have ports wb_pc, wb_instr  input  32 each  PC and encoding of the retiring instruction.
REQ-006 SHALL have ports wb_rd_we  input  1, wb_rd  input  5, wb_rd_data  input  32  register writeback.
REQ-007 SHALL have ports wb_mem_we  input  1, wb_mem_addr  input  32, wb_mem_data  input  32  store issued by this instruction.
REQ-008 SHALL have port wb_halt  input  1  the retiring instruction is the halt.
REQ-009 SHALL have ports tr_valid  output  1, tr_ready  input  1  trace handshake to the checker.
REQ-010 SHALL have output record ports tr_seq 32, tr_pc 32, tr_instr 32, tr_rd_we 1, tr_rd 5, tr_rd_data 32, tr_mem_we 1, tr_mem_addr 32, tr_mem_data 32, tr_last 1.
REQ-011 SHALL have outputs stall_req 1 (backpressure to CPU), overflow 1 (sticky drop flag), done 1 (trace complete), count clog2(DEPTH)+1 (occupancy).

Function
REQ-012 Push: SHALL enqueue one record per cycle when wb_valid=1 and state=RUN.
REQ-013 Record SHALL hold wb_* fields, tr_seq = retire counter value, tr_last = wb_halt.
REQ-014 Retire counter SHALL start at 0 and increment by 1 on every wb_valid in RUN, including dropped records; wraps 0xFFFFFFFF -> 0.
REQ-015 x0 rule: when wb_rd=0, stored tr_rd_we SHALL be 0 and tr_rd_data 0.
REQ-016 Pop: SHALL dequeue head when tr_valid=1 and tr_ready=1 on a clock edge.
REQ-017 tr_valid SHALL equal (count>0); record outputs SHALL reflect FIFO head, stable while tr_valid=1 and tr_ready=0.
REQ-018 Latency: push into empty FIFO at edge N -> tr_valid=1 after edge N, same cycle data visible.
REQ-019 Simultaneous push and pop SHALL both occur; count unchanged; allowed also when full.
REQ-020 Full (count=DEPTH) with push and no pop: record SHALL be dropped, overflow set to 1 and held until reset; counter still increments.
REQ-021 stall_req SHALL be combinational, 1 when count >= DEPTH-2, absorbing one cycle of CPU stall latency.
REQ-022 Read/write pointers SHALL wrap modulo DEPTH.
REQ-023 State machine SHALL have states RUN, DRAIN, DONE.
REQ-024 RUN -> DRAIN on accepted or dropped push with wb_halt=1.
REQ-025 DRAIN: wb_valid SHALL be ignored (no push, no counter increment); pops continue.
REQ-026 DRAIN -> DONE when count=0 after the last record pops (or immediately if the halt record was dropped and FIFO empty).
REQ-027 DONE: done=1, no pushes, tr_valid=0; held until reset.
REQ-028 Halt record dropped on full SHALL still cause RUN -> DRAIN.

Reset
REQ-029 rst=1 SHALL immediately clear count, pointers, retire counter, overflow, done; state=RUN; tr_valid=0, stall_req=0.
REQ-030 Reset mid-drain or mid-transfer SHALL discard all queued records; no partial handshake completes.
REQ-031 Record storage need not be reset; outputs qualified by tr_valid only.

Verification
REQ-032 Single retire: wb_valid 1 cycle, pc=0x0, instr=0x00500093, rd=1, rd_data=5, tr_ready=1 -> tr_valid 1 cycle next cycle, tr_seq=0, tr_rd_we=1, tr_rd_data=5.
REQ-033 x0 write: instr=0x00000013 rd=0 rd_we=1 -> record tr_rd_we=0, tr_rd_data=0.
REQ-034 Backpressure: tr_ready=0, 10 consecutive retires with DEPTH=8 -> stall_req=1 at count=6; entries seq 0..7 retained, seq 8,9 dropped, overflow=1; release tr_ready -> 8 records seq 0..7 in order.
REQ-035 Simultaneous push/pop at full: count stays 8, no overflow, output order preserved.
REQ-036 Halt: store to 0x10 data 0xDEADBEEF, then halt instr with wb_halt=1, then 2 more wb_valid -> 2 records, second tr_last=1, tr_seq=1; extra retires ignored; done=1 after last pop.
REQ-037 Async reset asserted mid-cycle with count=3 in DRAIN -> tr_valid=0, count=0, state RUN without clock edge; next retire tr_seq=0.
